ccip_port_mux: RTL and testbench



---
 rtl/ccip_mux_pkg.sv | 24 ++
 rtl/ccip_rr_arbiter.sv | 49 ++++
 rtl/ccip_port_mux.sv | 188 ++++++++++++++++++
 tb/tb_ccip_port_mux.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccip_mux_pkg.sv
// Shared defaults and helpers for the CCI-P port multiplexer.
// Holds the default interface widths, the outstanding-counter width and a
// helper that extracts the port index carried in the top bits of mdata.
package ccip_mux_pkg;

  localparam int unsigned DEF_NUM_PORTS       = 4;
  localparam int unsigned DEF_MAX_OUTSTANDING = 64;
  localparam int unsigned DEF_ADDR_W          = 42;
  localparam int unsigned DEF_DATA_W          = 512;
  localparam int unsigned DEF_MDATA_W         = 16;
  localparam int unsigned OUT_CNT_W           = 8;

  // Port index lives in mdata[mdataW-1 -: portW]; mdata is passed zero-extended.
  function automatic int unsigned portOfMdata(input logic [31:0] mdata,
                                              input int unsigned mdataW,
                                              input int unsigned portW);
    logic [31:0] shifted;
    logic [31:0] mask;
    shifted = mdata >> (mdataW - portW);
    mask    = (32'd1 << portW) - 32'd1;
    return shifted & mask;
  endfunction

endpackage

// File: rtl/ccip_rr_arbiter.sv
// Round-robin arbiter with a combinational one-hot grant.
// Ports: clk, rst_n (async active-low), req[N], almostfull (blocks all grants),
//        grant[N] one-hot. The priority pointer moves to one past the winner
//        after each grant and holds otherwise; reset returns it to port 0.
module ccip_rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         almostfull,
  output logic [N-1:0] grant
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] nextPtr;
  logic [N-1:0]     reqQ;
  logic [N-1:0]     hiMask;
  logic [N-1:0]     hiReq;
  logic [N-1:0]     pick;

  // Requests at or above the pointer take priority; if none, wrap to the
  // full set. The lowest set bit of the chosen set is the winner.
  always_comb begin
    reqQ   = almostfull ? '0 : req;
    hiMask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      hiMask[i] = (PTR_W'(i) >= ptr);
    end
    hiReq = reqQ & hiMask;
    pick  = (hiReq != '0) ? hiReq : reqQ;
    grant = pick & (~pick + {{(N-1){1'b0}}, 1'b1});
  end

  always_comb begin
    nextPtr = ptr;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) nextPtr = (i == N - 1) ? '0 : PTR_W'(i + 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= nextPtr;
  end

endmodule

// File: rtl/ccip_port_mux.sv
// Multiplexes NUM_PORTS AFU request ports onto one CCI-P TX channel pair and
// demultiplexes RX responses back by the port index carried in mdata.
// Ports: port_rd_* / port_wr_* per-port request handshakes and fields;
//        spl_tx_*_almostfull downstream backpressure; afu_tx_* merged,
//        registered requests; spl_rx_* responses in; port_rx_* demuxed,
//        registered responses on shared buses; err_bad_port / err_underflow
//        sticky flags; stat_rd_cnt per-port read-grant counters.
// Build option: define CCIP_MUX_STATS_EN to enable the read-grant counters;
// otherwise stat_rd_cnt is tied to zero.
module ccip_port_mux
  import ccip_mux_pkg::*;
#(
  parameter int unsigned NUM_PORTS       = DEF_NUM_PORTS,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int unsigned ADDR_W          = DEF_ADDR_W,
  parameter int unsigned DATA_W          = DEF_DATA_W,
  parameter int unsigned MDATA_W         = DEF_MDATA_W,
  parameter int unsigned PORT_W          = $clog2(NUM_PORTS),
  parameter int unsigned UMD_W           = MDATA_W - PORT_W
) (
  input  logic                          clk,
  input  logic                          spl_reset_n,
  input  logic [NUM_PORTS-1:0]          port_rd_valid,
  output logic [NUM_PORTS-1:0]          port_rd_ready,
  input  logic [NUM_PORTS*ADDR_W-1:0]   port_rd_addr,
  input  logic [NUM_PORTS*UMD_W-1:0]    port_rd_mdata,
  input  logic [NUM_PORTS-1:0]          port_wr_valid,
  output logic [NUM_PORTS-1:0]          port_wr_ready,
  input  logic [NUM_PORTS*ADDR_W-1:0]   port_wr_addr,
  input  logic [NUM_PORTS*UMD_W-1:0]    port_wr_mdata,
  input  logic [NUM_PORTS*DATA_W-1:0]   port_wr_data,
  input  logic                          spl_tx_rd_almostfull,
  input  logic                          spl_tx_wr_almostfull,
  output logic                          afu_tx_rd_valid,
  output logic [ADDR_W-1:0]             afu_tx_rd_addr,
  output logic [MDATA_W-1:0]            afu_tx_rd_mdata,
  output logic                          afu_tx_wr_valid,
  output logic [ADDR_W-1:0]             afu_tx_wr_addr,
  output logic [MDATA_W-1:0]            afu_tx_wr_mdata,
  output logic [DATA_W-1:0]             afu_tx_data,
  input  logic                          spl_rx_rd_valid,
  input  logic [MDATA_W-1:0]            spl_rx_rd_mdata,
  input  logic [DATA_W-1:0]             spl_rx_data,
  input  logic                          spl_rx_wr_valid,
  input  logic [MDATA_W-1:0]            spl_rx_wr_mdata,
  output logic [NUM_PORTS-1:0]          port_rx_rd_valid,
  output logic [UMD_W-1:0]              port_rx_rd_mdata,
  output logic [DATA_W-1:0]             port_rx_data,
  output logic [NUM_PORTS-1:0]          port_rx_wr_valid,
  output logic [UMD_W-1:0]              port_rx_wr_mdata,
  output logic                          err_bad_port,
  output logic                          err_underflow,
  output logic [NUM_PORTS*32-1:0]       stat_rd_cnt
);

  logic [OUT_CNT_W-1:0] outstanding [NUM_PORTS];
  logic [NUM_PORTS-1:0] rdElig, wrReq, rdGrant, wrGrant;
  logic [NUM_PORTS-1:0] rdRspHit, wrRspHit, outZero;
  logic [ADDR_W-1:0]    rdSelAddr, wrSelAddr;
  logic [UMD_W-1:0]     rdSelMd, wrSelMd;
  logic [PORT_W-1:0]    rdSelIdx, wrSelIdx;
  logic [DATA_W-1:0]    wrSelData;
  int unsigned          rdRspIdx, wrRspIdx;
  logic                 rdRspBad, wrRspBad, underflowNow;

  // Requests are masked while reset is asserted so ready reads 0 immediately.
  always_comb begin
    rdElig = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      rdElig[i] = port_rd_valid[i] && spl_reset_n &&
                  (outstanding[i] < OUT_CNT_W'(MAX_OUTSTANDING));
    end
    wrReq = port_wr_valid & {NUM_PORTS{spl_reset_n}};
  end

  ccip_rr_arbiter #(.N(NUM_PORTS)) uRdArb (
    .clk(clk), .rst_n(spl_reset_n), .req(rdElig),
    .almostfull(spl_tx_rd_almostfull), .grant(rdGrant)
  );

  ccip_rr_arbiter #(.N(NUM_PORTS)) uWrArb (
    .clk(clk), .rst_n(spl_reset_n), .req(wrReq),
    .almostfull(spl_tx_wr_almostfull), .grant(wrGrant)
  );

  assign port_rd_ready = rdGrant;
  assign port_wr_ready = wrGrant;

  always_comb begin
    rdSelAddr = '0; rdSelMd = '0; rdSelIdx = '0;
    wrSelAddr = '0; wrSelMd = '0; wrSelIdx = '0; wrSelData = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (rdGrant[i]) begin
        rdSelAddr = port_rd_addr[i*ADDR_W +: ADDR_W];
        rdSelMd   = port_rd_mdata[i*UMD_W +: UMD_W];
        rdSelIdx  = PORT_W'(i);
      end
      if (wrGrant[i]) begin
        wrSelAddr = port_wr_addr[i*ADDR_W +: ADDR_W];
        wrSelMd   = port_wr_mdata[i*UMD_W +: UMD_W];
        wrSelData = port_wr_data[i*DATA_W +: DATA_W];
        wrSelIdx  = PORT_W'(i);
      end
    end
  end

  // Response routing by the port index in the top mdata bits.
  always_comb begin
    rdRspIdx = portOfMdata(32'(spl_rx_rd_mdata), MDATA_W, PORT_W);
    wrRspIdx = portOfMdata(32'(spl_rx_wr_mdata), MDATA_W, PORT_W);
    rdRspBad = (rdRspIdx >= NUM_PORTS);
    wrRspBad = (wrRspIdx >= NUM_PORTS);
    rdRspHit = '0;
    wrRspHit = '0;
    outZero  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      rdRspHit[i] = spl_rx_rd_valid && !rdRspBad && (rdRspIdx == i);
      wrRspHit[i] = spl_rx_wr_valid && !wrRspBad && (wrRspIdx == i);
      outZero[i]  = (outstanding[i] == '0);
    end
    underflowNow = |(rdRspHit & ~rdGrant & outZero);
  end

  always_ff @(posedge clk or negedge spl_reset_n) begin
    if (!spl_reset_n) begin
      afu_tx_rd_valid  <= 1'b0;
      afu_tx_wr_valid  <= 1'b0;
      port_rx_rd_valid <= '0;
      port_rx_wr_valid <= '0;
      err_bad_port     <= 1'b0;
      err_underflow    <= 1'b0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) outstanding[i] <= '0;
    end else begin
      afu_tx_rd_valid  <= |rdGrant;
      afu_tx_wr_valid  <= |wrGrant;
      port_rx_rd_valid <= rdRspHit;
      port_rx_wr_valid <= wrRspHit;
      err_bad_port     <= err_bad_port | (spl_rx_rd_valid && rdRspBad) |
                          (spl_rx_wr_valid && wrRspBad);
      err_underflow    <= err_underflow | underflowNow;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        case ({rdGrant[i], rdRspHit[i]})
          2'b10:   outstanding[i] <= outstanding[i] + 1'b1;
          2'b01:   if (!outZero[i]) outstanding[i] <= outstanding[i] - 1'b1;
          default: outstanding[i] <= outstanding[i];
        endcase
      end
    end
  end

  // Payload registers carry no reset; they are qualified by the valids.
  always_ff @(posedge clk) begin
    if (|rdGrant) begin
      afu_tx_rd_addr  <= rdSelAddr;
      afu_tx_rd_mdata <= {rdSelIdx, rdSelMd};
    end
    if (|wrGrant) begin
      afu_tx_wr_addr  <= wrSelAddr;
      afu_tx_wr_mdata <= {wrSelIdx, wrSelMd};
      afu_tx_data     <= wrSelData;
    end
    port_rx_rd_mdata <= spl_rx_rd_mdata[UMD_W-1:0];
    port_rx_data     <= spl_rx_data;
    port_rx_wr_mdata <= spl_rx_wr_mdata[UMD_W-1:0];
  end

`ifdef CCIP_MUX_STATS_EN
  logic [31:0] statCnt [NUM_PORTS];

  always_ff @(posedge clk or negedge spl_reset_n) begin
    if (!spl_reset_n) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) statCnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (rdGrant[i]) statCnt[i] <= statCnt[i] + 32'd1;
      end
    end
  end

  always_comb begin
    stat_rd_cnt = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) stat_rd_cnt[i*32 +: 32] = statCnt[i];
  end
`else
  assign stat_rd_cnt = '0;
`endif

endmodule

// File: tb/tb_ccip_port_mux.sv
module tb_ccip_port_mux;
  localparam int NP = 4, AW = 42, DW = 512, MW = 16, UW = 14, MAXO = 64;
`ifdef CCIP_MUX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [NP-1:0] rdValid, wrValid;
  logic [NP*AW-1:0] rdAddr, wrAddr;
  logic [NP*UW-1:0] rdMd, wrMd;
  logic [NP*DW-1:0] wrData;
  logic rdAf, wrAf, rxRdValid, rxWrValid;
  logic [MW-1:0] rxRdMd, rxWrMd;
  logic [DW-1:0] rxData;

  logic [NP-1:0] port_rd_ready, port_wr_ready, port_rx_rd_valid, port_rx_wr_valid;
  logic afu_tx_rd_valid, afu_tx_wr_valid, err_bad_port, err_underflow;
  logic [AW-1:0] afu_tx_rd_addr, afu_tx_wr_addr;
  logic [MW-1:0] afu_tx_rd_mdata, afu_tx_wr_mdata;
  logic [DW-1:0] afu_tx_data, port_rx_data;
  logic [UW-1:0] port_rx_rd_mdata, port_rx_wr_mdata;
  logic [NP*32-1:0] stat_rd_cnt;

  // Second instance with 3 ports so an out-of-range port index exists.
  logic rx3Valid;
  logic [MW-1:0] rx3Md;
  logic [2:0] rdReady3, wrReady3, rxRdValid3, rxWrValid3;
  logic afuRdValid3, afuWrValid3, errBad3, errUnder3;
  logic [AW-1:0] afuRdAddr3, afuWrAddr3;
  logic [MW-1:0] afuRdMd3, afuWrMd3;
  logic [DW-1:0] afuData3, rxData3;
  logic [UW-1:0] rxRdMd3, rxWrMd3;
  logic [3*32-1:0] stat3;

  int checks = 0, failures = 0;
  int mOut[NP];
  int mRdPtr, mWrPtr;
  logic mUnder;
  int unsigned mStat[NP];

  ccip_port_mux #(.NUM_PORTS(NP), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .spl_reset_n(rst_n),
    .port_rd_valid(rdValid), .port_rd_ready(port_rd_ready),
    .port_rd_addr(rdAddr), .port_rd_mdata(rdMd),
    .port_wr_valid(wrValid), .port_wr_ready(port_wr_ready),
    .port_wr_addr(wrAddr), .port_wr_mdata(wrMd), .port_wr_data(wrData),
    .spl_tx_rd_almostfull(rdAf), .spl_tx_wr_almostfull(wrAf),
    .afu_tx_rd_valid(afu_tx_rd_valid), .afu_tx_rd_addr(afu_tx_rd_addr),
    .afu_tx_rd_mdata(afu_tx_rd_mdata),
    .afu_tx_wr_valid(afu_tx_wr_valid), .afu_tx_wr_addr(afu_tx_wr_addr),
    .afu_tx_wr_mdata(afu_tx_wr_mdata), .afu_tx_data(afu_tx_data),
    .spl_rx_rd_valid(rxRdValid), .spl_rx_rd_mdata(rxRdMd), .spl_rx_data(rxData),
    .spl_rx_wr_valid(rxWrValid), .spl_rx_wr_mdata(rxWrMd),
    .port_rx_rd_valid(port_rx_rd_valid), .port_rx_rd_mdata(port_rx_rd_mdata),
    .port_rx_data(port_rx_data),
    .port_rx_wr_valid(port_rx_wr_valid), .port_rx_wr_mdata(port_rx_wr_mdata),
    .err_bad_port(err_bad_port), .err_underflow(err_underflow),
    .stat_rd_cnt(stat_rd_cnt)
  );

  ccip_port_mux #(.NUM_PORTS(3)) dut3 (
    .clk(clk), .spl_reset_n(rst_n),
    .port_rd_valid(3'b000), .port_rd_ready(rdReady3),
    .port_rd_addr('0), .port_rd_mdata('0),
    .port_wr_valid(3'b000), .port_wr_ready(wrReady3),
    .port_wr_addr('0), .port_wr_mdata('0), .port_wr_data('0),
    .spl_tx_rd_almostfull(1'b0), .spl_tx_wr_almostfull(1'b0),
    .afu_tx_rd_valid(afuRdValid3), .afu_tx_rd_addr(afuRdAddr3),
    .afu_tx_rd_mdata(afuRdMd3),
    .afu_tx_wr_valid(afuWrValid3), .afu_tx_wr_addr(afuWrAddr3),
    .afu_tx_wr_mdata(afuWrMd3), .afu_tx_data(afuData3),
    .spl_rx_rd_valid(rx3Valid), .spl_rx_rd_mdata(rx3Md), .spl_rx_data(rxData),
    .spl_rx_wr_valid(1'b0), .spl_rx_wr_mdata('0),
    .port_rx_rd_valid(rxRdValid3), .port_rx_rd_mdata(rxRdMd3),
    .port_rx_data(rxData3),
    .port_rx_wr_valid(rxWrValid3), .port_rx_wr_mdata(rxWrMd3),
    .err_bad_port(errBad3), .err_underflow(errUnder3),
    .stat_rd_cnt(stat3)
  );

  // Reference: scan ports starting at the pointer, first eligible wins.
  function automatic logic [NP-1:0] rrPick(input logic [NP-1:0] elig, input int ptr);
    logic [NP-1:0] one;
    one = 1;
    for (int k = 0; k < NP; k++) begin
      int p;
      p = (ptr + k) % NP;
      if (elig[p]) return one << p;
    end
    return '0;
  endfunction

  function automatic int idxOf(input logic [NP-1:0] oh);
    for (int i = 0; i < NP; i++) if (oh[i]) return i;
    return -1;
  endfunction

  function automatic logic [NP*DW-1:0] randWide();
    logic [NP*DW-1:0] r;
    for (int i = 0; i < NP*DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic resetModel();
    for (int p = 0; p < NP; p++) begin mOut[p] = 0; mStat[p] = 0; end
    mRdPtr = 0; mWrPtr = 0; mUnder = 1'b0;
  endtask

  task automatic clearInputs();
    rdValid = '0; wrValid = '0; rdAf = 1'b0; wrAf = 1'b0;
    rxRdValid = 1'b0; rxWrValid = 1'b0; rx3Valid = 1'b0;
    rdAddr = '0; wrAddr = '0; rdMd = '0; wrMd = '0; wrData = '0;
    rxRdMd = '0; rxWrMd = '0; rxData = '0; rx3Md = '0;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    clearInputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    resetModel();
    @(posedge clk); #1;
  endtask

  task automatic randomizeFields();
    logic [NP*DW-1:0] w;
    w = randWide(); rdAddr = w[NP*AW-1:0];
    w = randWide(); wrAddr = w[NP*AW-1:0];
    w = randWide(); rdMd = w[NP*UW-1:0];
    w = randWide(); wrMd = w[NP*UW-1:0];
    wrData = randWide();
    w = randWide(); rxData = w[DW-1:0];
  endtask

  // One clock with full comparison against the reference; entered and left
  // 1 time unit after a rising edge. Response inputs are one-shot.
  task automatic cycle();
    logic [NP-1:0] elig, expRd, expWr, expRxRdV, expRxWrV;
    logic [NP*32-1:0] expStat;
    logic [MW-1:0] expRdMd, expWrMd;
    logic [AW-1:0] expRdAddr, expWrAddr;
    logic [DW-1:0] expWrData, expRxData;
    logic [UW-1:0] expRxRdMd, expRxWrMd;
    int gRd, gWr, rIdx, wIdx;
    logic inc, dec;
    #2;
    for (int p = 0; p < NP; p++) elig[p] = rdValid[p] && (mOut[p] < MAXO);
    expRd = rdAf ? '0 : rrPick(elig, mRdPtr);
    expWr = wrAf ? '0 : rrPick(wrValid, mWrPtr);
    checks++;
    if (port_rd_ready !== expRd) begin
      failures++; $display("FAIL rd_ready got=%b exp=%b t=%0t", port_rd_ready, expRd, $time);
    end
    checks++;
    if (port_wr_ready !== expWr) begin
      failures++; $display("FAIL wr_ready got=%b exp=%b t=%0t", port_wr_ready, expWr, $time);
    end
    gRd = idxOf(expRd);
    gWr = idxOf(expWr);
    expRdAddr = '0; expRdMd = '0; expWrAddr = '0; expWrMd = '0; expWrData = '0;
    if (gRd >= 0) begin
      expRdAddr = rdAddr[gRd*AW +: AW];
      expRdMd   = {2'(gRd), rdMd[gRd*UW +: UW]};
    end
    if (gWr >= 0) begin
      expWrAddr = wrAddr[gWr*AW +: AW];
      expWrMd   = {2'(gWr), wrMd[gWr*UW +: UW]};
      expWrData = wrData[gWr*DW +: DW];
    end
    rIdx = int'(rxRdMd[MW-1 -: 2]);
    wIdx = int'(rxWrMd[MW-1 -: 2]);
    expRxRdV  = rxRdValid ? (4'b0001 << rIdx) : 4'b0000;
    expRxWrV  = rxWrValid ? (4'b0001 << wIdx) : 4'b0000;
    expRxRdMd = rxRdMd[UW-1:0];
    expRxWrMd = rxWrMd[UW-1:0];
    expRxData = rxData;
    for (int p = 0; p < NP; p++) begin
      inc = expRd[p];
      dec = rxRdValid && (rIdx == p);
      if (inc && !dec) mOut[p]++;
      else if (dec && !inc) begin
        if (mOut[p] == 0) mUnder = 1'b1;
        else mOut[p]--;
      end
      if (inc) mStat[p]++;
      expStat[p*32 +: 32] = STATS ? mStat[p] : 32'd0;
    end
    if (gRd >= 0) mRdPtr = (gRd + 1) % NP;
    if (gWr >= 0) mWrPtr = (gWr + 1) % NP;
    @(posedge clk); #1;
    checks++;
    if (afu_tx_rd_valid !== (gRd >= 0)) begin
      failures++; $display("FAIL afu_rd_valid got=%b exp=%b t=%0t", afu_tx_rd_valid, gRd >= 0, $time);
    end
    if (gRd >= 0) begin
      checks++;
      if (afu_tx_rd_addr !== expRdAddr || afu_tx_rd_mdata !== expRdMd) begin
        failures++; $display("FAIL afu_rd_fields got=%h/%h exp=%h/%h", afu_tx_rd_addr, afu_tx_rd_mdata, expRdAddr, expRdMd);
      end
    end
    checks++;
    if (afu_tx_wr_valid !== (gWr >= 0)) begin
      failures++; $display("FAIL afu_wr_valid got=%b exp=%b t=%0t", afu_tx_wr_valid, gWr >= 0, $time);
    end
    if (gWr >= 0) begin
      checks++;
      if (afu_tx_wr_addr !== expWrAddr || afu_tx_wr_mdata !== expWrMd || afu_tx_data !== expWrData) begin
        failures++; $display("FAIL afu_wr_fields got=%h/%h exp=%h/%h", afu_tx_wr_addr, afu_tx_wr_mdata, expWrAddr, expWrMd);
      end
    end
    checks++;
    if (port_rx_rd_valid !== expRxRdV) begin
      failures++; $display("FAIL rx_rd_valid got=%b exp=%b t=%0t", port_rx_rd_valid, expRxRdV, $time);
    end
    if (rxRdValid) begin
      checks++;
      if (port_rx_rd_mdata !== expRxRdMd || port_rx_data !== expRxData) begin
        failures++; $display("FAIL rx_rd_fields got=%h exp=%h", port_rx_rd_mdata, expRxRdMd);
      end
    end
    checks++;
    if (port_rx_wr_valid !== expRxWrV) begin
      failures++; $display("FAIL rx_wr_valid got=%b exp=%b t=%0t", port_rx_wr_valid, expRxWrV, $time);
    end
    if (rxWrValid) begin
      checks++;
      if (port_rx_wr_mdata !== expRxWrMd) begin
        failures++; $display("FAIL rx_wr_mdata got=%h exp=%h", port_rx_wr_mdata, expRxWrMd);
      end
    end
    checks++;
    if (err_underflow !== mUnder || err_bad_port !== 1'b0) begin
      failures++; $display("FAIL err_flags got=%b/%b exp=%b/0", err_underflow, err_bad_port, mUnder);
    end
    checks++;
    if (stat_rd_cnt !== expStat) begin
      failures++; $display("FAIL stat_rd_cnt got=%h exp=%h", stat_rd_cnt, expStat);
    end
    rxRdValid = 1'b0;
    rxWrValid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clearInputs();
    rdValid = '1; wrValid = '1;
    #2;
    checks++;
    if ({afu_tx_rd_valid, afu_tx_wr_valid, port_rx_rd_valid, port_rx_wr_valid,
         port_rd_ready, port_wr_ready, err_bad_port, err_underflow} !== '0 || stat_rd_cnt !== '0) begin
      failures++; $display("FAIL reset_state rdv=%b wrv=%b rdy=%b/%b err=%b%b", afu_tx_rd_valid,
                           afu_tx_wr_valid, port_rd_ready, port_wr_ready, err_bad_port, err_underflow);
    end
    applyReset();
  endtask

  task automatic test_alternate();
    applyReset();
    rdValid = 4'b0101;
    for (int i = 0; i < 6; i++) begin
      randomizeFields();
      cycle();
      checks++;
      if (afu_tx_rd_valid !== 1'b1 || afu_tx_rd_mdata[15:14] !== ((i % 2 == 0) ? 2'd0 : 2'd2)) begin
        failures++; $display("FAIL alternate i=%0d got=%b/%0d exp=1/%0d", i, afu_tx_rd_valid,
                             afu_tx_rd_mdata[15:14], (i % 2 == 0) ? 0 : 2);
      end
    end
    rdValid = '0;
  endtask

  task automatic test_outstanding_limit();
    applyReset();
    rdValid = 4'b0010;
    for (int i = 0; i < 64; i++) begin randomizeFields(); cycle(); end
    #2;
    checks++;
    if (port_rd_ready !== 4'b0000) begin
      failures++; $display("FAIL limit_block got=%b exp=0000", port_rd_ready);
    end
    rxRdValid = 1'b1; rxRdMd = 16'h4005;
    cycle();
    checks++;
    if (port_rx_rd_valid !== 4'b0010 || port_rx_rd_mdata !== 14'h0005) begin
      failures++; $display("FAIL limit_rsp got=%b/%h exp=0010/0005", port_rx_rd_valid, port_rx_rd_mdata);
    end
    #2;
    checks++;
    if (port_rd_ready !== 4'b0010) begin
      failures++; $display("FAIL limit_resume got=%b exp=0010", port_rd_ready);
    end
    cycle();
    rdValid = '0;
  endtask

  task automatic test_almostfull();
    applyReset();
    rdValid = '1;
    randomizeFields();
    cycle();
    rdAf = 1'b1;
    checks++;
    if (afu_tx_rd_valid !== 1'b1) begin
      failures++; $display("FAIL af_inflight got=%b exp=1", afu_tx_rd_valid);
    end
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (afu_tx_rd_valid !== 1'b0) begin
        failures++; $display("FAIL af_block i=%0d got=%b exp=0", i, afu_tx_rd_valid);
      end
    end
    rdAf = 1'b0;
    #2;
    checks++;
    if (port_rd_ready !== 4'b0010) begin
      failures++; $display("FAIL af_resume got=%b exp=0010", port_rd_ready);
    end
    cycle();
    rdValid = '0;
  endtask

  task automatic test_same_cycle();
    applyReset();
    rdValid = 4'b1000;
    for (int i = 0; i < 5; i++) cycle();
    rxRdValid = 1'b1; rxRdMd = {2'd3, 14'($urandom)};
    cycle();
    rdValid = '0;
    for (int i = 0; i < 5; i++) begin
      rxRdValid = 1'b1; rxRdMd = {2'd3, 14'($urandom)};
      cycle();
    end
    checks++;
    if (err_underflow !== 1'b0) begin
      failures++; $display("FAIL same_cycle_count got=%b exp=0", err_underflow);
    end
    rxRdValid = 1'b1; rxRdMd = {2'd3, 14'h0};
    cycle();
    checks++;
    if (err_underflow !== 1'b1 || port_rx_rd_valid !== 4'b1000) begin
      failures++; $display("FAIL underflow got=%b/%b exp=1/1000", err_underflow, port_rx_rd_valid);
    end
  endtask

  task automatic test_stats();
    int grants;
    applyReset();
    grants = 0;
    rdValid = 4'b0001;
    for (int i = 0; i < 100; i++) begin
      randomizeFields();
      if (mOut[0] > 0) begin rxRdValid = 1'b1; rxRdMd = {2'd0, 14'($urandom)}; end
      cycle();
      grants++;
    end
    rdValid = '0;
    rxRdValid = 1'b1; rxRdMd = 16'h0000;
    cycle();
    checks++;
    if (stat_rd_cnt[31:0] !== (STATS ? 32'(grants) : 32'd0)) begin
      failures++; $display("FAIL stats got=%0d exp=%0d", stat_rd_cnt[31:0], STATS ? grants : 0);
    end
  endtask

  task automatic test_random();
    int p;
    applyReset();
    for (int i = 0; i < 300; i++) begin
      randomizeFields();
      rdValid = 4'($urandom);
      wrValid = 4'($urandom);
      rdAf = ($urandom_range(0, 4) == 0);
      wrAf = ($urandom_range(0, 4) == 0);
      p = $urandom_range(0, NP-1);
      if ($urandom_range(0, 1) == 1 && mOut[p] > 0) begin
        rxRdValid = 1'b1; rxRdMd = {2'(p), 14'($urandom)};
      end
      if ($urandom_range(0, 2) == 0) begin
        rxWrValid = 1'b1; rxWrMd = 16'($urandom);
      end
      cycle();
    end
    clearInputs();
  endtask

  task automatic test_bad_port();
    rx3Valid = 1'b1; rx3Md = 16'hC000;
    @(posedge clk); #1;
    rx3Valid = 1'b0;
    checks++;
    if (rxRdValid3 !== 3'b000 || errBad3 !== 1'b1) begin
      failures++; $display("FAIL bad_port got=%b/%b exp=000/1", rxRdValid3, errBad3);
    end
    rx3Valid = 1'b1; rx3Md = 16'h8003;
    @(posedge clk); #1;
    rx3Valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rxRdValid3 !== 3'b000 || errBad3 !== 1'b1) begin
      failures++; $display("FAIL bad_port_sticky got=%b/%b exp=000/1", rxRdValid3, errBad3);
    end
    rx3Valid = 1'b1; rx3Md = 16'h8003;
    @(posedge clk); #1;
    rx3Valid = 1'b0;
    checks++;
    if (rxRdValid3 !== 3'b100 || rxRdMd3 !== 14'h0003) begin
      failures++; $display("FAIL port2_of3 got=%b/%h exp=100/0003", rxRdValid3, rxRdMd3);
    end
  endtask

  task automatic test_async_reset();
    applyReset();
    rdValid = '1; wrValid = '1;
    for (int i = 0; i < 3; i++) begin randomizeFields(); cycle(); end
    rxRdValid = 1'b1; rxRdMd = 16'h8001;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({afu_tx_rd_valid, afu_tx_wr_valid, port_rx_rd_valid, port_rx_wr_valid,
         port_rd_ready, port_wr_ready, err_bad_port, err_underflow, errBad3} !== '0 || stat_rd_cnt !== '0) begin
      failures++; $display("FAIL async_reset rdv=%b wrv=%b rdy=%b/%b err=%b%b%b", afu_tx_rd_valid,
                           afu_tx_wr_valid, port_rd_ready, port_wr_ready, err_bad_port, err_underflow, errBad3);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    resetModel();
    rdValid = '0; wrValid = '0;
    rxRdValid = 1'b1; rxRdMd = {2'd2, 14'h0011};
    cycle();
    checks++;
    if (err_underflow !== 1'b1 || port_rx_rd_valid !== 4'b0100) begin
      failures++; $display("FAIL stale_tag got=%b/%b exp=1/0100", err_underflow, port_rx_rd_valid);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    resetModel();
    test_reset();
    test_alternate();
    test_outstanding_limit();
    test_almostfull();
    test_same_cycle();
    test_stats();
    test_random();
    test_bad_port();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
